datapath_seq: RTL and testbench

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_seq_pkg.sv | 28 ++
 rtl/datapath_seq_alu_seq.sv | 64 ++++++
 rtl/datapath_seq.sv | 189 ++++++++++++++++++
 tb/tb_datapath_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_seq_pkg.sv
// Shared encodings for the datapath_seq sequencer: opcodes, operand selects, FSM states.
package datapath_seq_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL1 = 3'd5;
   localparam logic [2:0] OP_ASR1 = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   localparam logic [1:0] SELA_EXT  = 2'b00;
   localparam logic [1:0] SELA_RAM  = 2'b01;
   localparam logic [1:0] SELA_ALU  = 2'b10;
   localparam logic [1:0] SELA_HOLD = 2'b11;

   localparam logic SELB_EXT = 1'b0;
   localparam logic SELB_RAM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/datapath_seq_alu_seq.sv
// Combinational ALU for datapath_seq. Flag outputs {Z,N,C,V} exist only when
// DATAPATH_SEQ_FLAGS_EN is defined.
module alu_seq
   import datapath_seq_pkg::*;
#(
   parameter int E_BITS  = 16,
   parameter int OP_BITS = 3
) (
   input  logic [E_BITS-1:0]  i_a,
   input  logic [E_BITS-1:0]  i_b,
   input  logic [OP_BITS-1:0] i_op,
   output logic [E_BITS-1:0]  o_res
`ifdef DATAPATH_SEQ_FLAGS_EN
   ,
   output logic [3:0]         o_flags
`endif
);

   // result select; unused opcode values (wider OP_BITS) yield zero
   always_comb begin
      o_res = '0;
      case (i_op)
         OP_BITS'(OP_ADD):  o_res = i_a + i_b;
         OP_BITS'(OP_SUB):  o_res = i_a - i_b;
         OP_BITS'(OP_AND):  o_res = i_a & i_b;
         OP_BITS'(OP_OR):   o_res = i_a | i_b;
         OP_BITS'(OP_XOR):  o_res = i_a ^ i_b;
         OP_BITS'(OP_SHL1): o_res = {i_a[E_BITS-2:0], 1'b0};
         OP_BITS'(OP_ASR1): o_res = {i_a[E_BITS-1], i_a[E_BITS-1:1]};
         OP_BITS'(OP_PASS): o_res = i_b;
         default:           o_res = '0;
      endcase
   end

`ifdef DATAPATH_SEQ_FLAGS_EN
   logic [E_BITS:0] sum;
   logic [E_BITS:0] diff;
   logic            c_flag;
   logic            v_flag;

   // carry is no-borrow for SUB and the shifted-out bit for shifts
   always_comb begin
      sum    = {1'b0, i_a} + {1'b0, i_b};
      diff   = {1'b0, i_a} - {1'b0, i_b};
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (i_op)
         OP_BITS'(OP_ADD): begin
            c_flag = sum[E_BITS];
            v_flag = (i_a[E_BITS-1] == i_b[E_BITS-1]) && (o_res[E_BITS-1] != i_a[E_BITS-1]);
         end
         OP_BITS'(OP_SUB): begin
            c_flag = ~diff[E_BITS];
            v_flag = (i_a[E_BITS-1] != i_b[E_BITS-1]) && (o_res[E_BITS-1] != i_a[E_BITS-1]);
         end
         OP_BITS'(OP_SHL1): c_flag = i_a[E_BITS-1];
         OP_BITS'(OP_ASR1): c_flag = i_a[0];
         default: ;
      endcase
      o_flags = {(o_res == '0), o_res[E_BITS-1], c_flag, v_flag};
   end
`endif

endmodule

// File: rtl/datapath_seq.sv
// Accumulator sequencer: latches a command, optionally fetches a RAM operand,
// executes one ALU/load step and reports completion.
// Optional feature macro: DATAPATH_SEQ_FLAGS_EN (registered {Z,N,C,V} flags).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_start; command fields latched on start
// ST_FETCH | o_ram_req high, waiting for i_ram_valid or timeout
// ST_EXEC  | single cycle; accumulator (and flags) written at exit edge
// ST_DONE  | o_done high for one cycle, o_err qualifies it
module datapath_seq
   import datapath_seq_pkg::*;
#(
   parameter int E_BITS  = 16,
   parameter int D_BITS  = 11,
   parameter int OP_BITS = 3,
   parameter int TMO_CYC = 15
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [D_BITS-1:0]  i_Data,
   input  logic [OP_BITS-1:0] i_op,
   input  logic [1:0]         sel_A,
   input  logic               sel_B,
   input  logic               w_acc,
   input  logic [E_BITS-1:0]  i_Data_ram,
   input  logic               i_ram_valid,
   output logic               o_ram_req,
   output logic [D_BITS-1:0]  o_Addr_ram,
   output logic [E_BITS-1:0]  o_Data_ram,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic [3:0]         o_flags
);

   localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

   state_e               state_q, state_d;
   logic [E_BITS-1:0]    acc_q, acc_d;
   logic [D_BITS-1:0]    addr_q, addr_d;
   logic [OP_BITS-1:0]   op_q, op_d;
   logic [1:0]           sela_q, sela_d;
   logic                 selb_q, selb_d;
   logic                 wacc_q, wacc_d;
   logic [E_BITS-1:0]    ram_q, ram_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 err_q, err_d;

   logic [E_BITS-1:0]    imm_ext;
   logic [E_BITS-1:0]    alu_b;
   logic [E_BITS-1:0]    alu_res;

   assign imm_ext = {{(E_BITS-D_BITS){addr_q[D_BITS-1]}}, addr_q};
   assign alu_b   = (selb_q == SELB_RAM) ? ram_q : imm_ext;

`ifdef DATAPATH_SEQ_FLAGS_EN
   logic [3:0] flags_q, flags_d;
   logic [3:0] alu_flags;

   alu_seq #(.E_BITS(E_BITS), .OP_BITS(OP_BITS)) u_alu (
      .i_a     (acc_q),
      .i_b     (alu_b),
      .i_op    (op_q),
      .o_res   (alu_res),
      .o_flags (alu_flags)
   );
`else
   alu_seq #(.E_BITS(E_BITS), .OP_BITS(OP_BITS)) u_alu (
      .i_a     (acc_q),
      .i_b     (alu_b),
      .i_op    (op_q),
      .o_res   (alu_res)
   );
`endif

   // next-state and datapath updates
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      addr_d  = addr_q;
      op_d    = op_q;
      sela_d  = sela_q;
      selb_d  = selb_q;
      wacc_d  = wacc_q;
      ram_d   = ram_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
`ifdef DATAPATH_SEQ_FLAGS_EN
      flags_d = flags_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               addr_d = i_Data;
               op_d   = i_op;
               sela_d = sel_A;
               selb_d = sel_B;
               wacc_d = w_acc;
               err_d  = 1'b0;
               if ((sel_A == SELA_RAM) || ((sel_A == SELA_ALU) && (sel_B == SELB_RAM))) begin
                  state_d = ST_FETCH;
                  tmo_d   = TMO_W'(TMO_CYC - 1);
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_FETCH: begin
            // a valid in the final allowed cycle still wins over the timeout
            if (i_ram_valid) begin
               ram_d   = i_Data_ram;
               tmo_d   = '0;
               state_d = ST_EXEC;
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         ST_EXEC: begin
            if (wacc_q) begin
               case (sela_q)
                  SELA_EXT: acc_d = imm_ext;
                  SELA_RAM: acc_d = ram_q;
                  SELA_ALU: begin
                     acc_d = alu_res;
`ifdef DATAPATH_SEQ_FLAGS_EN
                     flags_d = alu_flags;
`endif
                  end
                  default: acc_d = acc_q;
               endcase
            end
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         addr_q  <= '0;
         op_q    <= '0;
         sela_q  <= SELA_EXT;
         selb_q  <= SELB_EXT;
         wacc_q  <= 1'b0;
         ram_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         sela_q  <= sela_d;
         selb_q  <= selb_d;
         wacc_q  <= wacc_d;
         ram_q   <= ram_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

`ifdef DATAPATH_SEQ_FLAGS_EN
   // flag register, only written by ALU results
   always_ff @(posedge i_clock) begin
      if (i_reset) flags_q <= '0;
      else         flags_q <= flags_d;
   end
   assign o_flags = flags_q;
`else
   assign o_flags = 4'b0000;
`endif

   assign o_ram_req  = (state_q == ST_FETCH);
   assign o_busy     = (state_q != ST_IDLE);
   assign o_done     = (state_q == ST_DONE);
   assign o_err      = o_done & err_q;
   assign o_Addr_ram = addr_q;
   assign o_Data_ram = acc_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Randomized and directed checks of datapath_seq against an arithmetic reference model.
module tb_datapath_seq;

   localparam int E = 16;
   localparam int D = 11;
   localparam int TMO = 15;
   localparam int MOD = 65536;
   localparam int HALF = 32768;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_start = 1'b0;
   logic [D-1:0]  i_Data = '0;
   logic [2:0]    i_op = '0;
   logic [1:0]    sel_A = '0;
   logic          sel_B = 1'b0;
   logic          w_acc = 1'b0;
   logic [E-1:0]  i_Data_ram = '0;
   logic          i_ram_valid = 1'b0;
   logic          o_ram_req;
   logic [D-1:0]  o_Addr_ram;
   logic [E-1:0]  o_Data_ram;
   logic          o_busy, o_done, o_err;
   logic [3:0]    o_flags;

   int n_assert = 0;
   int n_fail = 0;
   int acc_m = 0;
   logic [3:0] flags_m = 4'b0000;

   datapath_seq dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_Data      (i_Data),
      .i_op        (i_op),
      .sel_A       (sel_A),
      .sel_B       (sel_B),
      .w_acc       (w_acc),
      .i_Data_ram  (i_Data_ram),
      .i_ram_valid (i_ram_valid),
      .o_ram_req   (o_ram_req),
      .o_Addr_ram  (o_Addr_ram),
      .o_Data_ram  (o_Data_ram),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_flags     (o_flags)
   );

   always #5 i_clock = ~i_clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sext(input int d);
      return (d >= 1024) ? d - 2048 + MOD : d;
   endfunction

   function automatic int to_signed(input int a);
      return (a >= HALF) ? a - MOD : a;
   endfunction

   function automatic void model_alu(input int op, input int a, input int b,
                                     output int res, output logic [3:0] fl);
      int sa, sb;
      logic c, v;
      sa = to_signed(a);
      sb = to_signed(b);
      c = 1'b0;
      v = 1'b0;
      res = 0;
      case (op)
         0: begin res = (a + b) % MOD; c = (a + b) >= MOD; v = (sa + sb > HALF - 1) || (sa + sb < -HALF); end
         1: begin res = (a - b + MOD) % MOD; c = (a >= b); v = (sa - sb > HALF - 1) || (sa - sb < -HALF); end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: begin res = (a * 2) % MOD; c = (a >= HALF); end
         6: begin res = ((sa - (sa & 1)) / 2 + MOD) % MOD; c = ((a % 2) == 1); end
         default: res = b;
      endcase
      fl = {(res == 0), (res >= HALF), c, v};
   endfunction

   // one command; waits < 0 means RAM never answers
   task automatic run_cmd(input int d, input int op, input int sa, input int sb, input int wa,
                          input int waits, input int rdata);
      int ext, exp_acc, r, done_c, last_fetch;
      logic [3:0] fl, exp_fl;
      logic fetch, tmo_hit;
      ext = sext(d);
      fetch = (sa == 1) || (sa == 2 && sb == 1);
      tmo_hit = fetch && (waits < 0);
      exp_acc = acc_m;
      exp_fl = flags_m;
      if (!tmo_hit && wa == 1) begin
         case (sa)
            0: exp_acc = ext;
            1: exp_acc = rdata;
            2: begin
               model_alu(op, acc_m, (sb == 1) ? rdata : ext, r, fl);
               exp_acc = r;
`ifdef DATAPATH_SEQ_FLAGS_EN
               exp_fl = fl;
`endif
            end
            default: ;
         endcase
      end
      last_fetch = !fetch ? -1 : (tmo_hit ? TMO - 1 : waits);
      done_c = !fetch ? 1 : (tmo_hit ? TMO : waits + 2);

      @(negedge i_clock);
      i_start = 1'b1;
      i_Data = D'(d);
      i_op = 3'(op);
      sel_A = 2'(sa);
      sel_B = sb[0];
      w_acc = wa[0];
      i_ram_valid = 1'($urandom % 2);
      i_Data_ram = E'($urandom);
      @(posedge i_clock);
      #1;
      for (int c = 0; c <= done_c; c++) begin
         i_start = 1'($urandom % 2);
         i_Data = D'($urandom);
         i_op = 3'($urandom);
         sel_A = 2'($urandom);
         sel_B = 1'($urandom);
         w_acc = 1'($urandom);
         if (c <= last_fetch) begin
            i_ram_valid = (c == waits);
            i_Data_ram = (c == waits) ? E'(rdata) : E'($urandom);
            check("addr_fetch", o_Addr_ram, d);
         end else begin
            i_ram_valid = 1'($urandom % 2);
            i_Data_ram = E'($urandom);
         end
         check("busy", o_busy, 1);
         check("ram_req", o_ram_req, (c <= last_fetch) ? 1 : 0);
         check("done_timing", o_done, (c == done_c) ? 1 : 0);
         if (c == done_c) begin
            check("err", o_err, tmo_hit);
            check("acc", o_Data_ram, exp_acc);
            check("flags", o_flags, exp_fl);
            i_start = 1'b0;
            i_ram_valid = 1'b0;
         end else begin
            @(posedge i_clock);
            #1;
         end
      end
      @(posedge i_clock);
      #1;
      check("idle_busy", o_busy, 0);
      check("idle_done", o_done, 0);
      acc_m = exp_acc;
      flags_m = exp_fl;
   endtask

   task automatic check_reset_state();
      check("rst_acc", o_Data_ram, 0);
      check("rst_flags", o_flags, 0);
      check("rst_req", o_ram_req, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
      check("rst_addr", o_Addr_ram, 0);
   endtask

   initial begin
      int d, op, sa, sb, wa, w;
      logic [3:0] f_exp;
      repeat (3) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b0;
      #1;
      check_reset_state();

      // immediate 0x7FF sign-extends to all ones
      run_cmd(11'h7FF, 0, 0, 0, 1, 0, 0);
      check("imm_sext", o_Data_ram, 16'hFFFF);

      // 0x7FFF + 1 overflows into the sign bit
      run_cmd(0, 0, 1, 0, 1, 2, 16'h7FFF);
      run_cmd(1, 0, 2, 0, 1, 0, 0);
      check("add_ovf_acc", o_Data_ram, 16'h8000);
      f_exp = 4'b0000;
`ifdef DATAPATH_SEQ_FLAGS_EN
      f_exp = 4'b0101;
`endif
      check("add_ovf_flags", o_flags, f_exp);

      // 5 - RAM(5) after 3 wait cycles
      run_cmd(5, 0, 0, 0, 1, 0, 0);
      run_cmd(0, 1, 2, 1, 1, 3, 5);
      check("sub_zero_acc", o_Data_ram, 0);
      f_exp = 4'b0000;
`ifdef DATAPATH_SEQ_FLAGS_EN
      f_exp = 4'b1010;
`endif
      check("sub_zero_flags", o_flags, f_exp);

      // timeouts leave the accumulator alone
      run_cmd(11'h123, 0, 0, 0, 1, 0, 0);
      run_cmd(7, 0, 1, 0, 1, -1, 0);
      check("tmo_acc", o_Data_ram, 16'h0123);
      run_cmd(7, 0, 2, 1, 1, -1, 0);
      run_cmd(9, 0, 1, 0, 1, TMO - 1, 16'hBEEF);

      // hold select and write-disable
      run_cmd(11'h055, 0, 3, 0, 1, 0, 0);
      run_cmd(11'h066, 0, 0, 0, 0, 0, 0);
      check("hold_acc", o_Data_ram, 16'hBEEF);

      // reset in the middle of a fetch, with a start pulse while busy
      @(negedge i_clock);
      i_start = 1'b1;
      i_Data = 11'h3A5;
      sel_A = 2'b01;
      w_acc = 1'b1;
      @(negedge i_clock);
      i_Data = 11'h011;
      sel_A = 2'b00;
      @(negedge i_clock);
      i_start = 1'b0;
      check("midfetch_req", o_ram_req, 1);
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      i_ram_valid = 1'b1;
      i_Data_ram = 16'h5555;
      check_reset_state();
      acc_m = 0;
      flags_m = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clock);
         check("post_rst_done", o_done, 0);
         check("post_rst_acc", o_Data_ram, 0);
      end
      i_ram_valid = 1'b0;

      // randomized commands
      for (int n = 0; n < 60; n++) begin
         d = int'($urandom_range(0, 2047));
         op = int'($urandom_range(0, 7));
         sa = int'($urandom_range(0, 3));
         sb = int'($urandom_range(0, 1));
         wa = ($urandom_range(0, 7) != 0) ? 1 : 0;
         w = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
         run_cmd(d, op, sa, sb, wa, w, int'($urandom_range(0, MOD - 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
